// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the unified-RAM memory controller: length codes,
// controller states, request owners and small byte helpers.
package mem_ctrl_pkg;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  localparam logic [1:0] LenByte = 2'd0;
  localparam logic [1:0] LenHalf = 2'd1;
  localparam logic [1:0] LenWord = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_MEM
  } owner_t;

  // Length code 3 is an alias for a word access.
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      LenByte: return 3'd1;
      LenHalf: return 3'd2;
      LenWord: return 3'd4;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
    return word[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Bundle of the pipeline request ports (IF and MEM) and the byte-wide RAM port.
interface mem_ctrl_if;

  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;

  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_len;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_done;
  logic [31:0] mem_rdata;

  logic [31:0] ram_addr;
  logic        ram_wr;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din;

  modport master (
    output if_req, if_addr, mem_req, mem_wr, mem_len, mem_addr, mem_wdata, ram_din,
    input  if_done, if_data, mem_done, mem_rdata, ram_addr, ram_wr, ram_dout
  );

  modport slave (
    input  if_req, if_addr, mem_req, mem_wr, mem_len, mem_addr, mem_wdata, ram_din,
    output if_done, if_data, mem_done, mem_rdata, ram_addr, ram_wr, ram_dout
  );

endinterface

// File: rtl/mem_ctrl.sv
// Serializes IF and MEM accesses onto one byte-wide RAM port, MEM winning
// over IF; reads capture ram_din one cycle behind each issued address.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input logic       clk,
  input logic       rst,
  mem_ctrl_if.slave bus
);

  state_t      state;
  owner_t      owner;
  logic [31:0] base_addr;
  logic [31:0] wdata;
  logic [31:0] rbuf;
  logic [2:0]  nbytes;
  logic [2:0]  issue_cnt;
  logic [2:0]  cap_cnt;
  logic        cap_en;

  logic        acc_any;
  logic        acc_mem;
  logic [31:0] acc_addr;
  logic [2:0]  acc_nbytes;
  logic        acc_wr;
  logic [31:0] acc_wdata;
  logic [31:0] rword;

  // Arbitration view of the two requesters as seen while idle.
  always_comb begin
    acc_mem    = bus.mem_req;
    acc_any    = bus.mem_req | bus.if_req;
    acc_addr   = bus.if_addr;
    acc_nbytes = 3'd4;
    acc_wr     = 1'b0;
    acc_wdata  = ZeroWord;
    if (acc_mem) begin
      acc_addr   = bus.mem_addr;
      acc_nbytes = len_bytes(bus.mem_len);
      acc_wr     = bus.mem_wr;
      acc_wdata  = bus.mem_wdata;
    end
  end

  always_comb begin
    rword = rbuf | ({24'd0, bus.ram_din} << {cap_cnt[1:0], 3'b000});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      owner         <= OWN_NONE;
      base_addr     <= ZeroWord;
      wdata         <= ZeroWord;
      rbuf          <= ZeroWord;
      nbytes        <= 3'd0;
      issue_cnt     <= 3'd0;
      cap_cnt       <= 3'd0;
      cap_en        <= 1'b0;
      bus.if_done   <= 1'b0;
      bus.if_data   <= ZeroWord;
      bus.mem_done  <= 1'b0;
      bus.mem_rdata <= ZeroWord;
      bus.ram_addr  <= ZeroWord;
      bus.ram_wr    <= 1'b0;
      bus.ram_dout  <= 8'h00;
    end else begin
      bus.if_done  <= 1'b0;
      bus.mem_done <= 1'b0;
      case (state)
        IDLE: begin
          if (acc_any) begin
            owner        <= acc_mem ? OWN_MEM : OWN_IF;
            base_addr    <= acc_addr;
            nbytes       <= acc_nbytes;
            wdata        <= acc_wdata;
            rbuf         <= ZeroWord;
            issue_cnt    <= 3'd1;
            cap_cnt      <= 3'd0;
            cap_en       <= 1'b0;
            bus.ram_addr <= acc_addr;
            bus.ram_wr   <= acc_wr;
            if (acc_wr) begin
              bus.ram_dout <= acc_wdata[7:0];
            end
            state <= acc_wr ? WRITE : READ;
          end
        end

        READ: begin
          if (issue_cnt < nbytes) begin
            bus.ram_addr <= base_addr + {29'd0, issue_cnt};
            issue_cnt    <= issue_cnt + 3'd1;
          end
          cap_en <= 1'b1;
          // Data for the address shown last cycle is on ram_din now.
          if (cap_en) begin
            rbuf    <= rword;
            cap_cnt <= cap_cnt + 3'd1;
            if (cap_cnt == nbytes - 3'd1) begin
              state <= DONE;
              if (owner == OWN_IF) begin
                bus.if_done <= 1'b1;
                bus.if_data <= rword;
              end else begin
                bus.mem_done  <= 1'b1;
                bus.mem_rdata <= rword;
              end
            end
          end
        end

        WRITE: begin
          if (issue_cnt < nbytes) begin
            bus.ram_addr <= base_addr + {29'd0, issue_cnt};
            bus.ram_dout <= byte_sel(wdata, issue_cnt[1:0]);
            bus.ram_wr   <= 1'b1;
            issue_cnt    <= issue_cnt + 3'd1;
          end else begin
            bus.ram_wr <= 1'b0;
            state      <= DONE;
            if (owner == OWN_IF) begin
              bus.if_done <= 1'b1;
            end else begin
              bus.mem_done <= 1'b1;
            end
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Randomized self-checking bench for mem_ctrl against a byte-array memory
// model with latency and RAM-port sequence expectations.
module tb_mem_ctrl;

  logic clk;
  logic rst;

  mem_ctrl_if bus ();

  mem_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_compared;
  int n_mismatched;

  logic [7:0]  ram_m [0:65535];
  bit          ram_w [0:65535];
  logic        pre_we;
  logic [15:0] pre_addr;
  logic [7:0]  pre_data;

  logic [7:0]  model_m [0:65535];
  bit          model_w [0:65535];
  logic [31:0] exp_if_data;
  logic [31:0] exp_mem_rdata;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] initByte(input logic [15:0] a);
    logic [15:0] h;
    h = a * 16'd37 + 16'd5;
    return h[7:0];
  endfunction

  // RAM: registered read, one cycle behind the address; unwritten bytes hold a hash.
  always @(posedge clk) begin
    bus.ram_din <= ram_w[bus.ram_addr[15:0]] ? ram_m[bus.ram_addr[15:0]] : initByte(bus.ram_addr[15:0]);
    if (bus.ram_wr === 1'b1) begin
      ram_m[bus.ram_addr[15:0]] <= bus.ram_dout;
      ram_w[bus.ram_addr[15:0]] <= 1'b1;
    end else if (pre_we) begin
      ram_m[pre_addr] <= pre_data;
      ram_w[pre_addr] <= 1'b1;
    end
  end

  function automatic logic [7:0] modelRead(input logic [31:0] a);
    return model_w[a[15:0]] ? model_m[a[15:0]] : initByte(a[15:0]);
  endfunction

  task automatic modelWrite(input logic [31:0] a, input logic [7:0] d);
    model_m[a[15:0]] = d;
    model_w[a[15:0]] = 1'b1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [7:0] d);
    pre_we   = 1'b1;
    pre_addr = a[15:0];
    pre_data = d;
    modelWrite(a, d);
    @(posedge clk);
    #1;
    pre_we = 1'b0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_if_done"}, {31'd0, bus.if_done}, 32'd0);
    checkOutput({tag, "_if_data"}, bus.if_data, 32'd0);
    checkOutput({tag, "_mem_done"}, {31'd0, bus.mem_done}, 32'd0);
    checkOutput({tag, "_mem_rdata"}, bus.mem_rdata, 32'd0);
    checkOutput({tag, "_ram_addr"}, bus.ram_addr, 32'd0);
    checkOutput({tag, "_ram_wr"}, {31'd0, bus.ram_wr}, 32'd0);
    checkOutput({tag, "_ram_dout"}, {24'd0, bus.ram_dout}, 32'd0);
  endtask

  // One complete access from an idle controller; called in an idle cycle.
  task automatic applyStimulus(input bit use_if, input bit wr, input logic [1:0] len,
                               input logic [31:0] addr, input logic [31:0] wdata);
    int n;
    int lat;
    int k;
    bit got;
    logic [31:0] exp;
    n   = use_if ? 4 : ((len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4);
    lat = wr ? n + 1 : n + 2;
    exp = 32'd0;
    for (int i = 0; i < n; i++) exp[8*i +: 8] = modelRead(addr + 32'(i));
    if (use_if) begin
      bus.if_req  = 1'b1;
      bus.if_addr = addr;
    end else begin
      bus.mem_req   = 1'b1;
      bus.mem_wr    = wr;
      bus.mem_len   = len;
      bus.mem_addr  = addr;
      bus.mem_wdata = wdata;
    end
    k   = 0;
    got = 1'b0;
    while (!got && k < 40) begin
      @(posedge clk);
      #1;
      k++;
      if (k <= n) begin
        checkOutput("ram_addr", bus.ram_addr, addr + 32'(k - 1));
        checkOutput("ram_wr", {31'd0, bus.ram_wr}, {31'd0, wr});
        if (wr) checkOutput("ram_dout", {24'd0, bus.ram_dout}, {24'd0, wdata[8*(k-1) +: 8]});
      end
      got = use_if ? bus.if_done : bus.mem_done;
      checkOutput("other_done", {31'd0, use_if ? bus.mem_done : bus.if_done}, 32'd0);
    end
    if (!got) begin
      checkOutput("done_timeout", 32'd0, 32'd1);
    end else begin
      checkOutput("latency", 32'(k), 32'(lat));
      if (!wr) begin
        if (use_if) exp_if_data = exp;
        else        exp_mem_rdata = exp;
      end else begin
        for (int i = 0; i < n; i++) modelWrite(addr + 32'(i), wdata[8*i +: 8]);
      end
      checkOutput("if_data", bus.if_data, exp_if_data);
      checkOutput("mem_rdata", bus.mem_rdata, exp_mem_rdata);
      checkOutput("ram_wr_done", {31'd0, bus.ram_wr}, 32'd0);
    end
    bus.if_req  = 1'b0;
    bus.mem_req = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("done_pulse", {31'd0, bus.if_done | bus.mem_done}, 32'd0);
    checkOutput("ram_addr_hold", bus.ram_addr, addr + 32'(n - 1));
  endtask

  initial begin
    int k_mem;
    int k_if;
    logic [31:0] if_exp;
    n_compared    = 0;
    n_mismatched  = 0;
    exp_if_data   = 32'd0;
    exp_mem_rdata = 32'd0;
    pre_we        = 1'b0;
    pre_addr      = 16'd0;
    pre_data      = 8'd0;
    rst           = 1'b1;
    bus.if_req    = 1'b0;
    bus.if_addr   = 32'd0;
    bus.mem_req   = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.mem_len   = 2'd0;
    bus.mem_addr  = 32'd0;
    bus.mem_wdata = 32'd0;

    preload(32'h1000, 8'h13);
    preload(32'h1001, 8'h05);
    preload(32'h1002, 8'h10);
    preload(32'h1003, 8'h00);
    preload(32'h40, 8'h34);
    preload(32'h41, 8'h12);
    preload(32'hFFFFFFFE, 8'h11);
    preload(32'hFFFFFFFF, 8'h22);
    preload(32'h0, 8'h33);
    preload(32'h1, 8'h44);

    // Reset held two cycles with both requests pending.
    bus.if_req   = 1'b1;
    bus.if_addr  = 32'h1000;
    bus.mem_req  = 1'b1;
    bus.mem_addr = 32'h10;
    @(posedge clk);
    #1;
    checkResetOutputs("rst1");
    @(posedge clk);
    #1;
    checkResetOutputs("rst2");
    rst        = 1'b0;
    bus.if_req = 1'b0;
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h10, 32'd0);

    $display("[TB] directed accesses");
    applyStimulus(1'b1, 1'b0, 2'd2, 32'h1000, 32'd0);
    checkOutput("if_word_const", bus.if_data, 32'h00100513);
    applyStimulus(1'b0, 1'b1, 2'd0, 32'h20, 32'hDEADBEEF);
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h20, 32'd0);
    checkOutput("store_byte_readback", bus.mem_rdata, 32'h000000EF);
    applyStimulus(1'b0, 1'b0, 2'd2, 32'hFFFFFFFE, 32'd0);
    checkOutput("wrap_word_const", bus.mem_rdata, 32'h44332211);

    // Simultaneous IF and MEM requests: MEM first, IF right after.
    if_exp = {modelRead(32'h1003), modelRead(32'h1002), modelRead(32'h1001), modelRead(32'h1000)};
    bus.if_req   = 1'b1;
    bus.if_addr  = 32'h1000;
    bus.mem_req  = 1'b1;
    bus.mem_wr   = 1'b0;
    bus.mem_len  = 2'd1;
    bus.mem_addr = 32'h40;
    k_mem = -1;
    k_if  = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (bus.mem_done) begin
        k_mem = k;
        checkOutput("sim_mem_rdata", bus.mem_rdata, 32'h00001234);
        bus.mem_req = 1'b0;
      end
      if (bus.if_done) begin
        k_if = k;
        checkOutput("sim_if_data", bus.if_data, if_exp);
        bus.if_req = 1'b0;
      end
    end
    checkOutput("sim_mem_latency", 32'(k_mem), 32'd4);
    checkOutput("sim_if_latency", 32'(k_if), 32'd11);
    exp_mem_rdata = 32'h00001234;
    exp_if_data   = if_exp;

    // Reset in the middle of a word store.
    bus.mem_req   = 1'b1;
    bus.mem_wr    = 1'b1;
    bus.mem_len   = 2'd2;
    bus.mem_addr  = 32'h300;
    bus.mem_wdata = 32'hA1B2C3D4;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    checkOutput("mid_ram_wr", {31'd0, bus.ram_wr}, 32'd1);
    rst         = 1'b1;
    bus.mem_req = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("mid_rst_ram_wr", {31'd0, bus.ram_wr}, 32'd0);
    checkOutput("mid_rst_done", {31'd0, bus.mem_done}, 32'd0);
    @(posedge clk);
    #1;
    checkResetOutputs("mid_rst");
    rst = 1'b0;
    modelWrite(32'h300, 8'hD4);
    modelWrite(32'h301, 8'hC3);
    exp_if_data   = 32'd0;
    exp_mem_rdata = 32'd0;
    applyStimulus(1'b0, 1'b0, 2'd2, 32'h300, 32'd0);

    $display("[TB] random accesses");
    for (int i = 0; i < 40; i++) begin
      bit use_if;
      bit wr;
      logic [1:0] len;
      logic [31:0] addr;
      use_if = ($urandom_range(0, 2) == 0);
      wr     = !use_if && ($urandom_range(0, 1) == 1);
      len    = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) addr = 32'hFFFFFFF8 + 32'($urandom_range(0, 7));
      else                           addr = 32'h100 + 32'($urandom_range(0, 255));
      applyStimulus(use_if, wr, len, addr, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
